gpio_io: RTL and testbench

GPIO_IO -- requirements
Module: gpio_io

---
 rtl/gpio_pkg.sv | 31 +++
 rtl/gpio_debounce.sv | 80 ++++++++
 rtl/gpio_io.sv | 115 +++++++++++
 tb/tb_gpio_io.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared register map, field widths and state encodings for the GPIO block.
// Consumed by gpio_io, gpio_debounce, the SOC address decoder and the bench.
package gpio_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 16;

  localparam logic [ADDR_W-1:0] LED_OFFSET       = 4'h0;
  localparam logic [ADDR_W-1:0] BTN_STATE_OFFSET = 4'h4;
  localparam logic [ADDR_W-1:0] BTN_EDGE_OFFSET  = 4'h8;
  localparam logic [ADDR_W-1:0] IRQ_MASK_OFFSET  = 4'hC;

  typedef enum logic [1:0] {
    REG_LED       = 2'd0,
    REG_BTN_STATE = 2'd1,
    REG_BTN_EDGE  = 2'd2,
    REG_IRQ_MASK  = 2'd3
  } regSel_e;

  typedef enum logic {
    DB_STABLE = 1'b0,
    DB_CHECK  = 1'b1
  } dbState_e;

  // Word select from a byte offset; the two low address bits carry no meaning.
  function automatic regSel_e decodeReg(input logic [ADDR_W-1:0] addr);
    return regSel_e'(addr[3:2]);
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One button channel: 2-flop synchronizer feeding a STABLE/CHECK debounce FSM.
// rise_o pulses on the same edge the accepted level goes 0->1.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [CNT_W:0] TARGET = (CNT_W + 1)'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W:0] ONE    = (CNT_W + 1)'(1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  dbState_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cntNext;

  assign cntNext = {1'b0, cnt_q} + ONE;

  // The first differing sample already counts, so DEBOUNCE_CYCLES=1 accepts at once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      DB_STABLE: begin
        if (sync2_q != level_q) begin
          if (cntNext == TARGET) begin
            level_d = sync2_q;
          end else begin
            state_d = DB_CHECK;
            cnt_d   = cntNext[CNT_W-1:0];
          end
        end
      end
      DB_CHECK: begin
        if (sync2_q == level_q) begin
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (cntNext == TARGET) begin
          level_d = sync2_q;
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cntNext[CNT_W-1:0];
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_d & ~level_q;

endmodule

// File: rtl/gpio_io.sv
// GPIO peripheral: LED register, debounced buttons with sticky W1C edges, read port.
// Define GPIO_IRQ_EN to enable IRQ_MASK and the registered irq output.
module gpio_io
  import gpio_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int N_LED           = 5,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [N_BTN-1:0]  BUTTONS,
  output logic [N_LED-1:0]  leds,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_wr,
  input  logic              bus_rd,
  input  logic [DATA_W-1:0] bus_wdata,
  input  logic [3:0]        bus_wmask,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_rvalid,
  output logic              irq
);

  logic [N_BTN-1:0]  btnState, btnRise;
  logic [N_LED-1:0]  led_q, led_d;
  logic [N_BTN-1:0]  edge_q, edge_d;
  logic [N_BTN-1:0]  maskVal;
  logic [DATA_W-1:0] rdata_q, readData;
  logic              rvalid_q;
  logic              wrEn;
  regSel_e           sel;
  logic              unusedBusBits;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i  (CLK),
      .rst_i  (RESET),
      .btn_i  (BUTTONS[gi]),
      .level_o(btnState[gi]),
      .rise_o (btnRise[gi])
    );
  end

  assign sel           = decodeReg(bus_addr);
  assign wrEn          = bus_wr & bus_wmask[0];
  assign unusedBusBits = ^{bus_wdata, bus_wmask, bus_addr};

  // A new rising edge wins over a simultaneous write-1-to-clear of the same bit.
  always_comb begin
    led_d  = led_q;
    edge_d = edge_q;
    if (wrEn && sel == REG_LED) begin
      led_d = bus_wdata[N_LED-1:0];
    end
    if (wrEn && sel == REG_BTN_EDGE) begin
      edge_d = edge_q & ~bus_wdata[N_BTN-1:0];
    end
    edge_d = edge_d | btnRise;
  end

  always_comb begin
    readData = '0;
    case (sel)
      REG_LED:       readData[N_LED-1:0] = led_q;
      REG_BTN_STATE: readData[N_BTN-1:0] = btnState;
      REG_BTN_EDGE:  readData[N_BTN-1:0] = edge_q;
      REG_IRQ_MASK:  readData[N_BTN-1:0] = maskVal;
      default:       readData = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      led_q    <= '0;
      edge_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      led_q    <= led_d;
      edge_q   <= edge_d;
      rvalid_q <= bus_rd;
      rdata_q  <= bus_rd ? readData : '0;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [N_BTN-1:0] mask_q;
  logic             irq_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wrEn && sel == REG_IRQ_MASK) begin
        mask_q <= bus_wdata[N_BTN-1:0];
      end
      irq_q <= |(edge_q & mask_q);
    end
  end

  assign maskVal = mask_q;
  assign irq     = irq_q;
`else
  assign maskVal = '0;
  assign irq     = 1'b0;
`endif

  assign leds       = led_q;
  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;

endmodule

// File: tb/tb_gpio_io.sv
// Directed self-checking bench for gpio_io (N_BTN=3, N_LED=5, DEBOUNCE_CYCLES=4).
// Expectations follow GPIO_IRQ_EN so the same bench covers both builds.
module tb_gpio_io;
  import gpio_pkg::*;

  logic        CLK;
  logic        RESET;
  logic [2:0]  BUTTONS;
  logic [4:0]  leds;
  logic [3:0]  bus_addr;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] rd;
  logic        rv;

`ifdef GPIO_IRQ_EN
  localparam logic [31:0] EXP_MASK = 32'h4;
  localparam logic        EXP_IRQ  = 1'b1;
`else
  localparam logic [31:0] EXP_MASK = 32'h0;
  localparam logic        EXP_IRQ  = 1'b0;
`endif

  gpio_io #(
    .N_BTN(3),
    .N_LED(5),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BUTTONS   (BUTTONS),
    .leds      (leds),
    .bus_addr  (bus_addr),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .bus_wdata (bus_wdata),
    .bus_wmask (bus_wmask),
    .bus_rdata (bus_rdata),
    .bus_rvalid(bus_rvalid),
    .irq       (irq)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic busWrite(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    bus_addr  = a;
    bus_wdata = d;
    bus_wmask = m;
    bus_wr    = 1'b1;
    tick();
    bus_wr    = 1'b0;
    bus_wmask = 4'h0;
  endtask

  task automatic busRead(input logic [3:0] a, output logic [31:0] d, output logic v);
    bus_addr = a;
    bus_rd   = 1'b1;
    tick();
    bus_rd   = 1'b0;
    d        = bus_rdata;
    v        = bus_rvalid;
  endtask

  task automatic test_reset();
    RESET = 1'b1; BUTTONS = '0; bus_addr = '0; bus_wr = 0; bus_rd = 0;
    bus_wdata = '0; bus_wmask = '0;
    repeat (3) tick();
    vectors++;
    if ({leds, bus_rdata, bus_rvalid, irq} !== 39'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got leds=%h rdata=%h rvalid=%b irq=%b, want all 0",
               leds, bus_rdata, bus_rvalid, irq);
    end
    RESET = 1'b0;
    tick();
    busRead(BTN_STATE_OFFSET, rd, rv);
    vectors++;
    if (rd !== 32'h0 || rv !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_btn_state: got %h/%b want 0/1", rd, rv);
    end
    busRead(BTN_EDGE_OFFSET, rd, rv);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++; $display("[TB] FAIL reset_btn_edge: got %h want 0", rd);
    end
  endtask

  task automatic test_led();
    busWrite(LED_OFFSET, 32'h15, 4'h1);
    vectors++;
    if (leds !== 5'b10101) begin
      miscompares++; $display("[TB] FAIL led_write: got %b want 10101", leds);
    end
    busRead(LED_OFFSET, rd, rv);
    vectors++;
    if (rd !== 32'h15 || rv !== 1'b1) begin
      miscompares++; $display("[TB] FAIL led_read: got %h/%b want 15/1", rd, rv);
    end
    tick();
    vectors++;
    if (bus_rvalid !== 1'b0 || bus_rdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL rvalid_drop: got %b/%h want 0/0", bus_rvalid, bus_rdata);
    end
    busWrite(LED_OFFSET, 32'h0A, 4'hE);
    vectors++;
    if (leds !== 5'h15) begin
      miscompares++; $display("[TB] FAIL led_unmasked_write: got %h want 15", leds);
    end
    busWrite(LED_OFFSET, 32'hFF, 4'h1);
    busRead(LED_OFFSET, rd, rv);
    vectors++;
    if (leds !== 5'h1F || rd !== 32'h1F) begin
      miscompares++; $display("[TB] FAIL led_truncate: got %h/%h want 1f/1f", leds, rd);
    end
  endtask

  task automatic test_debounce_press();
    logic [31:0] exp;
    BUTTONS[0] = 1'b1;
    bus_addr = BTN_STATE_OFFSET;
    bus_rd = 1'b1;
    // Read sampled on edge n shows the state after edge n-1; accept lands on edge 6.
    for (int n = 1; n <= 7; n++) begin
      tick();
      exp = (n == 7) ? 32'h1 : 32'h0;
      vectors++;
      if (bus_rdata !== exp) begin
        miscompares++;
        $display("[TB] FAIL press_latency n=%0d: got %h want %h", n, bus_rdata, exp);
      end
    end
    bus_rd = 1'b0;
    busRead(BTN_EDGE_OFFSET, rd, rv);
    vectors++;
    if (rd !== 32'h1) begin
      miscompares++; $display("[TB] FAIL press_edge: got %h want 1", rd);
    end
    busWrite(BTN_EDGE_OFFSET, 32'h1, 4'h1);
    busRead(BTN_EDGE_OFFSET, rd, rv);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++; $display("[TB] FAIL edge_w1c: got %h want 0", rd);
    end
  endtask

  task automatic test_glitch();
    BUTTONS[1] = 1'b1;
    repeat (3) tick();
    BUTTONS[1] = 1'b0;
    repeat (10) tick();
    busRead(BTN_STATE_OFFSET, rd, rv);
    vectors++;
    if (rd !== 32'h1) begin
      miscompares++; $display("[TB] FAIL glitch_state: got %h want 1", rd);
    end
    busRead(BTN_EDGE_OFFSET, rd, rv);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++; $display("[TB] FAIL glitch_edge: got %h want 0", rd);
    end
  endtask

  task automatic test_w1c_collision();
    BUTTONS[0] = 1'b0;
    repeat (8) tick();
    BUTTONS[0] = 1'b1;
    repeat (8) tick();
    busRead(BTN_EDGE_OFFSET, rd, rv);
    vectors++;
    if (rd !== 32'h1) begin
      miscompares++; $display("[TB] FAIL collision_setup: got %h want 1", rd);
    end
    BUTTONS[0] = 1'b0;
    repeat (8) tick();
    BUTTONS[0] = 1'b1;
    repeat (5) tick();
    busWrite(BTN_EDGE_OFFSET, 32'h1, 4'h1);
    busRead(BTN_EDGE_OFFSET, rd, rv);
    vectors++;
    if (rd !== 32'h1) begin
      miscompares++; $display("[TB] FAIL collision_edge: got %h want 1", rd);
    end
    busRead(BTN_STATE_OFFSET, rd, rv);
    vectors++;
    if (rd !== 32'h1) begin
      miscompares++; $display("[TB] FAIL collision_state: got %h want 1", rd);
    end
    busWrite(BTN_EDGE_OFFSET, 32'h1, 4'h1);
    busRead(BTN_EDGE_OFFSET, rd, rv);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++; $display("[TB] FAIL collision_clear: got %h want 0", rd);
    end
  endtask

  task automatic test_back_to_back();
    bus_addr = LED_OFFSET; bus_wdata = 32'h3; bus_wmask = 4'h1;
    bus_wr = 1'b1; bus_rd = 1'b1;
    tick();
    bus_wr = 1'b0; bus_rd = 1'b0; bus_wmask = 4'h0;
    vectors++;
    if (bus_rdata !== 32'h1F || leds !== 5'h03) begin
      miscompares++;
      $display("[TB] FAIL rd_wr_same_cycle: got rdata=%h leds=%h want 1f/03", bus_rdata, leds);
    end
  endtask

  task automatic test_irq();
    busWrite(BTN_EDGE_OFFSET, 32'h7, 4'h1);
    busWrite(IRQ_MASK_OFFSET, 32'h4, 4'h1);
    busRead(IRQ_MASK_OFFSET, rd, rv);
    vectors++;
    if (rd !== EXP_MASK) begin
      miscompares++; $display("[TB] FAIL irq_mask_read: got %h want %h", rd, EXP_MASK);
    end
    BUTTONS[2] = 1'b1;
    repeat (6) tick();
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++; $display("[TB] FAIL irq_early: got %b want 0", irq);
    end
    tick();
    vectors++;
    if (irq !== EXP_IRQ) begin
      miscompares++; $display("[TB] FAIL irq_assert: got %b want %b", irq, EXP_IRQ);
    end
    busRead(BTN_EDGE_OFFSET, rd, rv);
    vectors++;
    if (rd !== 32'h4) begin
      miscompares++; $display("[TB] FAIL irq_edge: got %h want 4", rd);
    end
    busWrite(BTN_EDGE_OFFSET, 32'h4, 4'h1);
    vectors++;
    if (irq !== EXP_IRQ) begin
      miscompares++; $display("[TB] FAIL irq_hold: got %b want %b", irq, EXP_IRQ);
    end
    tick();
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++; $display("[TB] FAIL irq_clear: got %b want 0", irq);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    busWrite(LED_OFFSET, 32'h1F, 4'h1);
    BUTTONS[1] = 1'b1;
    repeat (3) tick();
    bus_addr = LED_OFFSET;
    bus_rd = 1'b1;
    #2 RESET = 1'b1;
    #1;
    vectors++;
    if ({leds, bus_rdata, bus_rvalid, irq} !== 39'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got leds=%h rdata=%h rvalid=%b irq=%b, want all 0",
               leds, bus_rdata, bus_rvalid, irq);
    end
    bus_rd = 1'b0;
    tick();
    RESET = 1'b0;
    tick();
    vectors++;
    if (bus_rvalid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL pending_read_dropped: got %b want 0", bus_rvalid);
    end
    bus_addr = BTN_STATE_OFFSET;
    bus_rd = 1'b1;
    for (int n = 2; n <= 7; n++) begin
      tick();
      exp = (n == 7) ? 32'h7 : 32'h0;
      vectors++;
      if (bus_rdata !== exp) begin
        miscompares++;
        $display("[TB] FAIL restart_latency n=%0d: got %h want %h", n, bus_rdata, exp);
      end
    end
    bus_rd = 1'b0;
    busRead(BTN_EDGE_OFFSET, rd, rv);
    vectors++;
    if (rd !== 32'h7) begin
      miscompares++; $display("[TB] FAIL restart_edges: got %h want 7", rd);
    end
    busRead(LED_OFFSET, rd, rv);
    vectors++;
    if (rd !== 32'h0 || leds !== 5'h0) begin
      miscompares++; $display("[TB] FAIL restart_led: got %h/%h want 0/0", rd, leds);
    end
  endtask

  initial begin
    test_reset();
    test_led();
    test_debounce_press();
    test_glitch();
    test_w1c_collision();
    test_back_to_back();
    test_irq();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
